pipelined_adder: RTL and testbench

Parametrised, pipelined ripple-carry adder/subtractor that replaces the purely combinational 8-bit adder wherever operands arrive on a clocked datapath. Operands are split into SEG-bit segments. Each segment is added in its own pipeline stage, and the carry is registered between stages. A valid/ready handshake on both sides provides back-pressure, so the block can sit between any two streaming datapath units.

---
 rtl/pipelined_adder.sv | 88 ++++++++
 tb/tb_pipelined_adder.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/pipelined_adder.sv
// pipelined_adder: SEG-bit-per-stage pipelined add/subtract with valid/ready back-pressure.
// Define ADDER_OVF_EN to add the registered signed-overflow output ovf.
module pipelined_adder #(
  parameter int WIDTH = 16,
  parameter int SEG   = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef ADDER_OVF_EN
  ,
  output logic             ovf
`endif
);
  localparam int STAGES = WIDTH / SEG;
  localparam int L      = STAGES - 1;
  localparam int XS     = (STAGES > 1) ? STAGES - 1 : 1;
  // Pending operand segments are kept shifted down so the next segment always sits in the low bits.
  logic [XS-1:0][WIDTH-1:0]     r_x, r_y;
  logic [STAGES-1:0][WIDTH-1:0] r_s, w_xi, w_yi, w_si, w_sn;
  logic [STAGES-1:0][SEG:0]     w_seg;
  logic [STAGES-1:0]            r_c, r_v, w_ci, w_vi;
  logic                         w_en;
  assign w_en      = !r_v[L] | out_ready;
  assign in_ready  = w_en;
  assign out_valid = r_v[L];
  assign sum       = r_s[L];
  assign cout      = r_c[L];
  always_comb begin
    w_xi    = '0;
    w_yi    = '0;
    w_ci    = '0;
    w_si    = '0;
    w_vi    = '0;
    w_seg   = '0;
    w_sn    = '0;
    w_xi[0] = x;
    w_yi[0] = sub ? ~y : y;
    w_ci[0] = cin ^ sub;
    w_vi[0] = in_valid;
    for (int k = 1; k < STAGES; k++) begin
      w_xi[k] = r_x[k-1];
      w_yi[k] = r_y[k-1];
      w_ci[k] = r_c[k-1];
      w_si[k] = r_s[k-1];
      w_vi[k] = r_v[k-1];
    end
    for (int k = 0; k < STAGES; k++) begin
      w_seg[k] = {1'b0, w_xi[k][SEG-1:0]} + {1'b0, w_yi[k][SEG-1:0]} + (SEG+1)'(w_ci[k]);
      w_sn[k]  = w_si[k] | (WIDTH'(w_seg[k][SEG-1:0]) << (k * SEG));
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_x <= '0;
      r_y <= '0;
      r_s <= '0;
      r_c <= '0;
      r_v <= '0;
    end else if (w_en) begin
      r_v <= w_vi;
      r_s <= w_sn;
      for (int k = 0; k < STAGES; k++) r_c[k] <= w_seg[k][SEG];
      for (int k = 0; k < STAGES - 1; k++) begin
        r_x[k] <= w_xi[k] >> SEG;
        r_y[k] <= w_yi[k] >> SEG;
      end
    end
  end
`ifdef ADDER_OVF_EN
  logic r_ovf;
  // Carry into the MSB is recovered as x^y^sum at that bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_ovf <= 1'b0;
    else if (w_en) r_ovf <= w_xi[L][SEG-1] ^ w_yi[L][SEG-1] ^ w_seg[L][SEG-1] ^ w_seg[L][SEG];
  end
  assign ovf = r_ovf;
`endif
endmodule

// File: tb/tb_pipelined_adder.sv
// tb_pipelined_adder: scoreboard bench for pipelined_adder (WIDTH=16, SEG=4).
module tb_pipelined_adder;
  typedef struct packed {logic [15:0] s; logic c; logic o;} res_t;
  logic clk = 0, rst_n = 0, in_valid = 0, cin = 0, sub = 0, out_ready = 1;
  logic in_ready, out_valid, cout;
  logic [15:0] x = 0, y = 0, sum;
`ifdef ADDER_OVF_EN
  logic ovf;
`endif
  res_t q[$];
  res_t mon_e;
  int n_pass = 0, n_tot = 0, pushed = 0, popped = 0;
  bit rnd_done = 0;

  always #5 clk = ~clk;

  pipelined_adder #(.WIDTH(16), .SEG(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .x(x), .y(y), .cin(cin), .sub(sub),
    .out_valid(out_valid), .out_ready(out_ready), .sum(sum), .cout(cout)
`ifdef ADDER_OVF_EN
    , .ovf(ovf)
`endif
  );

  function automatic res_t model(input logic [15:0] a, input logic [15:0] b, input logic c, input logic s);
    int d, sd, sa, sb;
    res_t r;
    sa = $signed(a);
    sb = $signed(b);
    d  = s ? int'(a) - int'(b) - int'(c) : int'(a) + int'(b) + int'(c);
    sd = s ? sa - sb - int'(c) : sa + sb + int'(c);
    r.s = d[15:0];
    r.c = s ? (d >= 0) : (d > 65535);
    r.o = (sd > 32767) || (sd < -32768);
    return r;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  always @(negedge clk)
    if (rst_n && in_valid && in_ready) begin
      q.push_back(model(x, y, cin, sub));
      pushed++;
    end

  always @(negedge clk)
    if (rst_n && out_valid && out_ready) begin
      if (q.size() == 0) chk("unexpected output", 1, 0);
      else begin
        mon_e = q.pop_front();
        popped++;
        chk("scoreboard sum", 32'(sum), 32'(mon_e.s));
        chk("scoreboard cout", 32'(cout), 32'(mon_e.c));
`ifdef ADDER_OVF_EN
        chk("scoreboard ovf", 32'(ovf), 32'(mon_e.o));
`endif
      end
    end

  task automatic send(input logic [15:0] a, input logic [15:0] b, input logic c, input logic s);
    int t = 0;
    x = a; y = b; cin = c; sub = s; in_valid = 1;
    do begin
      @(negedge clk);
      t++;
    end while (!in_ready && t < 100);
    if (!in_ready) chk("accept timeout", 0, 1);
    @(posedge clk);
    #1;
  endtask

  task automatic single(input logic [15:0] a, input logic [15:0] b, input logic c, input logic s,
                        input logic [15:0] es, input logic ec, input logic eo);
    send(a, b, c, s);
    in_valid = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("latency out_valid", 32'(out_valid), 32'(i == 3));
      if (i < 3) @(posedge clk);
    end
    chk("directed sum", 32'(sum), 32'(es));
    chk("directed cout", 32'(cout), 32'(ec));
`ifdef ADDER_OVF_EN
    chk("directed ovf", 32'(ovf), 32'(eo));
`else
    if (eo === 1'bx) chk("directed ovf", 0, 1);
`endif
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int t = 0;
    out_ready = 1;
    while (q.size() != 0 && t < 100) begin
      @(posedge clk);
      t++;
    end
    #1;
    chk("drain empty", 32'(q.size()), 0);
    chk("beat count", 32'(popped), 32'(pushed));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] hs;
    logic hc;
    #12;
    chk("reset out_valid", 32'(out_valid), 0);
    chk("reset sum", 32'(sum), 0);
    chk("reset cout", 32'(cout), 0);
    chk("reset in_ready", 32'(in_ready), 1);
    @(posedge clk);
    #1 rst_n = 1;
    @(posedge clk);
    #1;
    single(16'h00FF, 16'h0001, 0, 0, 16'h0100, 0, 0);
    single(16'hFFFF, 16'h0001, 0, 0, 16'h0000, 1, 0);
    single(16'h7FFF, 16'h0001, 0, 0, 16'h8000, 0, 1);
    single(16'h0005, 16'h0007, 0, 1, 16'hFFFE, 0, 0);
    single(16'h0009, 16'h0003, 1, 1, 16'h0005, 1, 0);
    single(16'h8000, 16'h0001, 0, 1, 16'h7FFF, 1, 1);
    fork
      begin
        for (int i = 0; i < 6; i++) send(16'($urandom) | 16'h0100, 16'($urandom), 1'($urandom), 1'($urandom));
        in_valid = 0;
      end
      begin
        repeat (5) @(posedge clk);
        #1 out_ready = 0;
        for (int i = 0; i < 3; i++) begin
          @(negedge clk);
          chk("stall in_ready", 32'(in_ready), 0);
          chk("stall out_valid", 32'(out_valid), 1);
          if (i == 0) begin
            hs = sum;
            hc = cout;
          end else begin
            chk("stall hold sum", 32'(sum), 32'(hs));
            chk("stall hold cout", 32'(cout), 32'(hc));
          end
          @(posedge clk);
        end
        #1 out_ready = 1;
      end
    join
    drain();
    fork
      begin
        for (int i = 0; i < 200; i++) begin
          send(16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom));
          if ($urandom_range(0, 3) == 0) begin
            in_valid = 0;
            repeat ($urandom_range(1, 3)) @(posedge clk);
            #1;
          end
        end
        in_valid = 0;
        rnd_done = 1;
      end
      begin
        while (!rnd_done) begin
          @(posedge clk);
          #1 out_ready = ($urandom_range(0, 3) != 0);
        end
      end
    join
    drain();
    single(16'h1234, 16'h4321, 0, 0, 16'h5555, 0, 0);
    for (int i = 0; i < 3; i++) send(16'h1111 * 16'(i + 1), 16'h0101, 0, 0);
    in_valid = 0;
    #1 rst_n = 0;
    #1;
    chk("mid reset out_valid", 32'(out_valid), 0);
    chk("mid reset sum", 32'(sum), 0);
    chk("mid reset in_ready", 32'(in_ready), 1);
    q.delete();
    @(posedge clk);
    #1 rst_n = 1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("post reset out_valid", 32'(out_valid), 0);
    end
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
